// File: rtl/signed_multiply_by_power_of_2_serial_if.sv
// Operand and result handshakes for the serial signed multiply-by-power-of-2 unit.
// The producer drives the master side; the shifter sits on the slave side.
interface signed_multiply_by_power_of_2_serial_if #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
);
    logic          up_valid;
    logic          up_ready;
    logic [N-1:0]  a;
    logic [SW-1:0] s;
    logic          down_valid;
    logic          down_ready;
    logic [N-1:0]  res;
    logic          ovf;

    modport master (
        output up_valid, a, s, down_ready,
        input  up_ready, down_valid, res, ovf
    );

    modport slave (
        input  up_valid, a, s, down_ready,
        output up_ready, down_valid, res, ovf
    );
endinterface

// File: rtl/signed_multiply_by_power_of_2_serial.sv
// Serial arithmetic left shift by a run-time amount, one bit per clock, with
// sticky overflow detection and saturation to the signed range on the way out.
module signed_multiply_by_power_of_2_serial #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input logic clk,
    input logic rst,
    signed_multiply_by_power_of_2_serial_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  acc;
    logic [SW-1:0] cnt;
    logic          sgn;
    logic          ovfR;
    logic          upReady;
    logic          downValid;
    logic [N-1:0]  resR;
    logic          ovfOut;

    logic [N-1:0]  shifted;
    logic          stepOvf;
    logic [N-1:0]  satVal;

    // A step overflows when the top two bits differ: doubling would flip the sign.
    assign shifted = {acc[N-2:0], 1'b0};
    assign stepOvf = ovfR | (acc[N-1] ^ acc[N-2]);
    assign satVal  = sgn ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            sgn       <= 1'b0;
            ovfR      <= 1'b0;
            upReady   <= 1'b1;
            downValid <= 1'b0;
            resR      <= '0;
            ovfOut    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.up_valid) begin
                        acc     <= bus.a;
                        cnt     <= bus.s;
                        sgn     <= bus.a[N-1];
                        ovfR    <= 1'b0;
                        upReady <= 1'b0;
                        if (bus.s == '0) begin
                            state     <= DONE;
                            downValid <= 1'b1;
                            resR      <= bus.a;
                            ovfOut    <= 1'b0;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    acc  <= shifted;
                    ovfR <= stepOvf;
                    cnt  <= cnt - SW'(1);
                    // Outputs are registered, so the final step publishes the result directly.
                    if (cnt == SW'(1)) begin
                        state     <= DONE;
                        downValid <= 1'b1;
                        ovfOut    <= stepOvf;
                        resR      <= stepOvf ? satVal : shifted;
                    end
                end
                DONE: begin
                    if (bus.down_ready) begin
                        state     <= IDLE;
                        downValid <= 1'b0;
                        resR      <= '0;
                        ovfOut    <= 1'b0;
                        upReady   <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    upReady   <= 1'b1;
                    downValid <= 1'b0;
                    resR      <= '0;
                    ovfOut    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.up_ready   = upReady;
    assign bus.down_valid = downValid;
    assign bus.res        = resR;
    assign bus.ovf        = ovfOut;
endmodule

// File: tb/tb_signed_multiply_by_power_of_2_serial.sv
// Directed bench for the serial signed multiply-by-power-of-2 unit (N = 8),
// with hand-computed results for fit, overflow, s = 0, backpressure and reset abort.
module tb_signed_multiply_by_power_of_2_serial;
    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    signed_multiply_by_power_of_2_serial_if #(.N(8)) bus ();

    signed_multiply_by_power_of_2_serial #(.N(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Presents one operand and returns #1 after the accepting edge.
    task automatic applyStimulus(input string tag, input logic [7:0] av, input logic [2:0] sv);
        checkOutput({tag, ".up_ready_idle"}, 32'(bus.up_ready), 32'd1);
        bus.up_valid = 1'b1;
        bus.a        = av;
        bus.s        = sv;
        @(posedge clk);
        #1;
        bus.up_valid = 1'b0;
        bus.a        = ~av;
        bus.s        = ~sv;
        checkOutput({tag, ".up_ready_busy"}, 32'(bus.up_ready), 32'd0);
    endtask

    task automatic awaitResult(input string tag, input int expLat,
                               input logic [7:0] expRes, input logic expOvf);
        int cycles;
        cycles = 0;
        while (bus.down_valid !== 1'b1 && cycles < 20) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput({tag, ".latency"}, 32'(cycles), 32'(expLat));
        checkOutput({tag, ".res"}, 32'(bus.res), 32'(expRes));
        checkOutput({tag, ".ovf"}, 32'(bus.ovf), 32'(expOvf));
    endtask

    task automatic finishHandshake(input string tag);
        bus.down_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({tag, ".post_valid"}, 32'(bus.down_valid), 32'd0);
        checkOutput({tag, ".post_ready"}, 32'(bus.up_ready), 32'd1);
        checkOutput({tag, ".post_res"}, 32'(bus.res), 32'd0);
    endtask

    task automatic runOp(input string tag, input logic [7:0] av, input logic [2:0] sv,
                         input logic [7:0] expRes, input logic expOvf);
        applyStimulus(tag, av, sv);
        awaitResult(tag, int'(sv), expRes, expOvf);
        finishHandshake(tag);
    endtask

    initial begin
        compared       = 0;
        mismatched     = 0;
        rst            = 1'b1;
        bus.up_valid   = 1'b0;
        bus.a          = '0;
        bus.s          = '0;
        bus.down_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset.up_ready", 32'(bus.up_ready), 32'd1);
        checkOutput("reset.down_valid", 32'(bus.down_valid), 32'd0);
        checkOutput("reset.res", 32'(bus.res), 32'd0);
        checkOutput("reset.ovf", 32'(bus.ovf), 32'd0);

        runOp("pos_fit", 8'h03, 3'd2, 8'h0C, 1'b0);
        runOp("neg_fit", 8'hFD, 3'd3, 8'hE8, 1'b0);
        runOp("neg_edge_fit", 8'hC0, 3'd1, 8'h80, 1'b0);
        runOp("pos_ovf", 8'h20, 3'd2, 8'h7F, 1'b1);
        runOp("neg_ovf", 8'hC0, 3'd2, 8'h80, 1'b1);
        runOp("minneg_ovf", 8'h80, 3'd1, 8'h80, 1'b1);
        runOp("one_s7_ovf", 8'h01, 3'd7, 8'h7F, 1'b1);
        runOp("zero_s7", 8'h00, 3'd7, 8'h00, 1'b0);
        runOp("s_zero", 8'h81, 3'd0, 8'h81, 1'b0);
        runOp("pos_s6_fit", 8'h01, 3'd6, 8'h40, 1'b0);

        // Backpressure: result must hold and a competing operand must be ignored.
        bus.down_ready = 1'b0;
        applyStimulus("bp", 8'h05, 3'd1);
        awaitResult("bp", 1, 8'h0A, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.up_valid = 1'b1;
            bus.a        = 8'h77;
            bus.s        = 3'd0;
            @(posedge clk);
            #1;
            checkOutput("bp.hold_valid", 32'(bus.down_valid), 32'd1);
            checkOutput("bp.hold_res", 32'(bus.res), 32'h0A);
            checkOutput("bp.hold_ovf", 32'(bus.ovf), 32'd0);
            checkOutput("bp.hold_ready", 32'(bus.up_ready), 32'd0);
        end
        bus.up_valid = 1'b0;
        finishHandshake("bp");
        @(posedge clk);
        #1;
        checkOutput("bp.single_handshake", 32'(bus.down_valid), 32'd0);
        checkOutput("bp.still_idle", 32'(bus.up_ready), 32'd1);

        // Reset during the second SHIFT cycle aborts the operation.
        applyStimulus("rst_abort", 8'h11, 3'd5);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_abort.up_ready", 32'(bus.up_ready), 32'd1);
        checkOutput("rst_abort.down_valid", 32'(bus.down_valid), 32'd0);
        checkOutput("rst_abort.res", 32'(bus.res), 32'd0);
        checkOutput("rst_abort.ovf", 32'(bus.ovf), 32'd0);
        repeat (6) @(posedge clk);
        #1;
        checkOutput("rst_abort.no_result", 32'(bus.down_valid), 32'd0);
        runOp("after_rst", 8'h11, 3'd1, 8'h22, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
